// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
// MEM_ARB_RR_EN selects round-robin arbitration instead of fixed LSU priority.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

    localparam logic REQ_IFU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

    localparam int STRB_W = 4;

    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Two-way request picker; grant[0]=IFU, grant[1]=LSU, one-hot or zero.
// MEM_ARB_RR_EN: on contention the requester not granted last wins.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

`ifdef MEM_ARB_RR_EN
    // Alternate on contention, otherwise serve whoever is asking.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b11:   grant = (last_grant == REQ_LSU) ? 2'b01 : 2'b10;
            2'b10:   grant = 2'b10;
            2'b01:   grant = 2'b01;
            default: grant = 2'b00;
        endcase
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    // LSU always wins on contention.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b11:   grant = 2'b10;
            2'b10:   grant = 2'b10;
            2'b01:   grant = 2'b01;
            default: grant = 2'b00;
        endcase
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the shared memory port: one outstanding transaction.
// MEM_ARB_RR_EN adds a last-grant flop and round-robin arbitration.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int SW = strb_width(DATA_W);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              owner_q;
    logic              accept;
    logic              idle;
    logic [1:0]        grant;
    logic              last_grant;

    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [SW-1:0]     wstrb_q;
    logic [DATA_W-1:0] ifu_rdata_q;
    logic [DATA_W-1:0] lsu_rdata_q;

    assign idle = (state_q == ST_IDLE);

    arb_pick u_pick (
        .valid      ({lsu_req_valid, ifu_req_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

`ifdef MEM_ARB_RR_EN
    logic last_grant_q;

    // Remember who won the most recent accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= REQ_IFU;
        end else if (accept) begin
            last_grant_q <= grant[1] ? REQ_LSU : REQ_IFU;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = REQ_IFU;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; responses outside WAIT are ignored.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    accept  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latch the winning request; IFU fetches carry no write payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= REQ_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (accept) begin
            if (grant[1]) begin
                owner_q <= REQ_LSU;
                addr_q  <= lsu_addr;
                wen_q   <= lsu_wen;
                wdata_q <= lsu_wdata;
                wstrb_q <= lsu_wstrb;
            end else begin
                owner_q <= REQ_IFU;
                addr_q  <= ifu_addr;
                wen_q   <= 1'b0;
                wdata_q <= '0;
                wstrb_q <= '0;
            end
        end
    end

    // Capture read data for the owner; stores complete with zero data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else if ((state_q == ST_WAIT) && mem_resp_valid) begin
            if (owner_q == REQ_LSU) begin
                lsu_rdata_q <= wen_q ? '0 : mem_rdata;
            end else begin
                ifu_rdata_q <= mem_rdata;
            end
        end
    end

    assign ifu_req_ready  = idle & grant[0] & ~rst;
    assign lsu_req_ready  = idle & grant[1] & ~rst;

    assign mem_req_valid  = (state_q == ST_REQ);
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wstrb      = wstrb_q;

    assign ifu_resp_valid = (state_q == ST_RESP) && (owner_q == REQ_IFU);
    assign lsu_resp_valid = (state_q == ST_RESP) && (owner_q == REQ_LSU);
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_rdata      = lsu_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations.
// Contention ordering follows MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MEM_ARB_RR_EN
    localparam bit LSU_FIRST = 1'b0;
`else
    localparam bit LSU_FIRST = 1'b1;
`endif

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wstrb      (lsu_wstrb),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered in REQ just after the accept edge; returns in RESP.
    task automatic serve(input int rdy_dly, input int rsp_dly,
                         input logic [31:0] data, input logic [31:0] ea,
                         input logic ew, input logic [31:0] ewd,
                         input logic [3:0] es);
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            chk("hold_valid", mem_req_valid, 1);
            chk("hold_addr", mem_addr, ea);
            chk("hold_wdata", mem_wdata, ewd);
            chk("hold_no_accept", {ifu_req_ready, lsu_req_ready}, 0);
            step();
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("req_valid", mem_req_valid, 1);
        chk("req_addr", mem_addr, ea);
        chk("req_wen", mem_wen, ew);
        chk("req_wdata", mem_wdata, ewd);
        chk("req_wstrb", mem_wstrb, es);
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < rsp_dly; i++) begin
            @(negedge clk);
            chk("wait_no_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
            chk("wait_no_req", mem_req_valid, 0);
            chk("wait_no_accept", {ifu_req_ready, lsu_req_ready}, 0);
            step();
        end
        mem_resp_valid = 1'b1;
        mem_rdata      = data;
        step();
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h5A5A5A5A;
    endtask

    initial begin
        rst            = 1'b1;
        ifu_req_valid  = 1'b1;
        ifu_addr       = 32'h0;
        lsu_req_valid  = 1'b1;
        lsu_addr       = 32'h0;
        lsu_wen        = 1'b0;
        lsu_wdata      = 32'h0;
        lsu_wstrb      = 4'h0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h5A5A5A5A;

        // Reset state, readies gated while valids are high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {ifu_req_ready, lsu_req_ready}, 0);
        chk("rst_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_mem_fields", {mem_addr, mem_wen, mem_wstrb}, 0);
        chk("rst_rdata", {ifu_rdata, lsu_rdata}, 0);
        step();
        rst           = 1'b0;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;

        // IFU read, zero-wait memory.
        step();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h80000000;
        @(negedge clk);
        chk("t1_ifu_ready", ifu_req_ready, 1);
        chk("t1_lsu_ready", lsu_req_ready, 0);
        chk("t1_mem_idle", mem_req_valid, 0);
        step();
        ifu_req_valid = 1'b0;
        serve(0, 0, 32'hDEADBEEF, 32'h80000000, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t1_ifu_resp", ifu_resp_valid, 1);
        chk("t1_ifu_rdata", ifu_rdata, 32'hDEADBEEF);
        chk("t1_lsu_quiet", {lsu_resp_valid, lsu_rdata}, 0);
        step();
        @(negedge clk);
        chk("t1_resp_pulse", ifu_resp_valid, 0);
        chk("t1_rdata_hold", ifu_rdata, 32'hDEADBEEF);

        // LSU store byte.
        step();
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h80000103;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'h000000AB;
        lsu_wstrb     = 4'b1000;
        @(negedge clk);
        chk("t2_lsu_ready", lsu_req_ready, 1);
        chk("t2_ifu_ready", ifu_req_ready, 0);
        step();
        lsu_req_valid = 1'b0;
        lsu_addr      = 32'h0;
        lsu_wdata     = 32'hFFFFFFFF;
        lsu_wstrb     = 4'h0;
        serve(0, 0, 32'h12345678, 32'h80000103, 1'b1, 32'h000000AB,
              4'b1000);
        @(negedge clk);
        chk("t2_lsu_resp", lsu_resp_valid, 1);
        chk("t2_lsu_rdata", lsu_rdata, 0);
        chk("t2_ifu_quiet", ifu_resp_valid, 0);
        step();
        @(negedge clk);
        chk("t2_resp_pulse", lsu_resp_valid, 0);
        chk("t2_ifu_rdata_hold", ifu_rdata, 32'hDEADBEEF);

        // Contention: both valid in the same idle cycle.
        step();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h80000010;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h80000200;
        lsu_wen       = 1'b0;
        lsu_wdata     = 32'h0;
        lsu_wstrb     = 4'hF;
        @(negedge clk);
        chk("t3_lsu_ready", lsu_req_ready, LSU_FIRST);
        chk("t3_ifu_ready", ifu_req_ready, !LSU_FIRST);
        step();
        if (LSU_FIRST) begin
            lsu_req_valid = 1'b0;
            serve(0, 0, 32'h11110000, 32'h80000200, 1'b0, 32'h0, 4'hF);
        end else begin
            ifu_req_valid = 1'b0;
            serve(0, 0, 32'h22220000, 32'h80000010, 1'b0, 32'h0, 4'h0);
        end
        @(negedge clk);
        chk("t3_first_resp",
            LSU_FIRST ? lsu_resp_valid : ifu_resp_valid, 1);
        chk("t3_first_rdata", LSU_FIRST ? lsu_rdata : ifu_rdata,
            LSU_FIRST ? 32'h11110000 : 32'h22220000);
        chk("t3_loser_blocked",
            LSU_FIRST ? ifu_req_ready : lsu_req_ready, 0);
        step();
        @(negedge clk);
        chk("t3_loser_ready",
            LSU_FIRST ? ifu_req_ready : lsu_req_ready, 1);
        step();
        if (LSU_FIRST) begin
            ifu_req_valid = 1'b0;
            serve(0, 0, 32'h22220000, 32'h80000010, 1'b0, 32'h0, 4'h0);
        end else begin
            lsu_req_valid = 1'b0;
            serve(0, 0, 32'h11110000, 32'h80000200, 1'b0, 32'h0, 4'hF);
        end
        @(negedge clk);
        chk("t3_second_resp",
            LSU_FIRST ? ifu_resp_valid : lsu_resp_valid, 1);
        chk("t3_second_rdata", LSU_FIRST ? ifu_rdata : lsu_rdata,
            LSU_FIRST ? 32'h22220000 : 32'h11110000);
        step();

        // Slow memory; IFU keeps a new request pending meanwhile.
        step();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h80000400;
        @(negedge clk);
        chk("t4_accept", ifu_req_ready, 1);
        step();
        ifu_addr = 32'h80000404;
        serve(5, 3, 32'h33334444, 32'h80000400, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t4_resp", ifu_resp_valid, 1);
        chk("t4_rdata", ifu_rdata, 32'h33334444);
        chk("t4_no_accept_resp", ifu_req_ready, 0);
        step();
        @(negedge clk);
        chk("t4_single_pulse", ifu_resp_valid, 0);
        chk("t4_next_accept", ifu_req_ready, 1);
        step();
        ifu_req_valid = 1'b0;
        serve(0, 0, 32'h55556666, 32'h80000404, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t4b_rdata", ifu_rdata, 32'h55556666);
        step();

        // Spurious memory response while idle.
        step();
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hBADBAD00;
        @(negedge clk);
        chk("t5_no_req", mem_req_valid, 0);
        step();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("t5_no_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        chk("t5_ifu_rdata", ifu_rdata, 32'h55556666);
        chk("t5_lsu_rdata", lsu_rdata, 32'h11110000);
        step();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h80000500;
        @(negedge clk);
        chk("t5_still_idle", ifu_req_ready, 1);
        step();
        ifu_req_valid = 1'b0;
        serve(0, 0, 32'h77778888, 32'h80000500, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t5_rdata", ifu_rdata, 32'h77778888);
        step();

        // Reset during WAIT, then recovery.
        step();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h80000800;
        @(negedge clk);
        chk("t6_accept", ifu_req_ready, 1);
        step();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_mem_valid", mem_req_valid, 0);
        chk("t6_async_addr", mem_addr, 0);
        chk("t6_async_rdata", {ifu_rdata, lsu_rdata}, 0);
        chk("t6_async_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        step();
        rst = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h80000C00;
        @(negedge clk);
        chk("t6_post_accept", ifu_req_ready, 1);
        step();
        ifu_req_valid = 1'b0;
        serve(0, 0, 32'hCAFEF00D, 32'h80000C00, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t6_post_resp", ifu_resp_valid, 1);
        chk("t6_post_rdata", ifu_rdata, 32'hCAFEF00D);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the core's single data/instruction memory port.
- Requester 0 is the IFU (instruction fetch, read-only); requester 1 is the LSU (loads and stores with byte strobes).
- Exactly one transaction is outstanding on the memory side at a time. The response is routed back to the requester that issued it.
- Sits between IFU/LSU and the memory bridge (DPI-backed model in simulation).

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  asynchronous, active-high reset
- ifu_req_valid  in  1  IFU request pending; held stable until ifu_req_ready
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  one-cycle pulse; ifu_rdata valid
- ifu_rdata  out  DATA_W  fetched word
- lsu_req_valid  in  1  LSU request pending; held stable until lsu_req_ready
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  access address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wstrb  in  DATA_W/8  byte strobes (sb=0001<<off, sh=0011<<off, sw=1111)
- lsu_resp_valid  out  1  one-cycle pulse; load data valid or store complete
- lsu_rdata  out  DATA_W  load data; 0 for stores
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  latched address
- mem_wen  out  1  latched write enable
- mem_wdata  out  DATA_W  latched write data
- mem_wstrb  out  DATA_W/8  latched strobes
- mem_resp_valid  in  1  memory response; exactly one per accepted request
- mem_rdata  in  DATA_W  read data

Behaviour:
- States are IDLE, REQ, WAIT, RESP. Owner register records the requester (IFU/LSU).
- Reset: state=IDLE, owner=IFU. All *_ready, *_resp_valid and mem_req_valid are 0. All latched address/data/strobe and rdata registers are 0.
- IDLE:
  - If any req_valid is high, the arbiter picks a winner combinationally and asserts that requester's req_ready in the same cycle.
  - It latches addr/wen/wdata/wstrb (IFU: wen=0, wstrb=0, wdata=0), sets owner, and moves to REQ.
  - Fixed priority: LSU wins over IFU.
  - The loser's req_ready stays 0 and it keeps valid asserted.
- REQ:
  - mem_req_valid=1 with the latched fields.
  - On mem_req_ready, go to WAIT. Otherwise hold; fields stay stable.
- WAIT:
  - On mem_resp_valid, capture mem_rdata into the owner's rdata register (0 if the access is a store) and go to RESP.
  - The memory side must not present mem_resp_valid in the same cycle as the request handshake. A response in REQ or IDLE is ignored.
- RESP:
  - The owner's resp_valid=1 for exactly one cycle; rdata holds the captured value.
  - Next state is IDLE.
  - A new request can be accepted no earlier than the cycle after RESP.
- Minimum latency, accept to resp_valid, with zero-wait memory: accept at cycle 0, mem_req_valid at 1 (ready at 1), resp at 2, resp_valid at 3. The arbiter accepts at most one request per 4 cycles.
- rdata registers hold their value until the next response to the same requester.
- Requester deasserting valid without handshake is illegal: no effect in REQ/WAIT, and not required to be handled.
- Reset asserted mid-transaction: immediate return to reset values. The outstanding memory transaction is abandoned and the memory model must be reset with it.
- Address and strobes pass through unmodified. No alignment checking; misalignment is the LSU's responsibility.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin. A last-grant flop (reset=IFU) is updated on each accept. When both requesters are valid in IDLE, the one not granted last wins.
- Undefined: fixed LSU priority as above, and the last-grant flop is absent.
- Single-requester behaviour is identical either way.

Decomposition:
- Shared package: state enum (IDLE/REQ/WAIT/RESP), requester ID constants (REQ_IFU=0, REQ_LSU=1), and the strobe-width constant.
- One sub-module, arb_pick: combinational 2-way picker with inputs valid[1:0] and last_grant, and output grant one-hot. It is conditioned on MEM_ARB_RR_EN.
- The FSM and datapath latches stay in mem_arbiter.

Test Plan:
- IFU alone reads 0x80000000, memory returns 0xDEADBEEF with zero wait → ifu_req_ready at cycle 0, mem_req_valid at 1, ifu_resp_valid pulse at 3 with ifu_rdata=0xDEADBEEF. LSU outputs stay 0.
- LSU sb to 0x80000103 with wdata 0x000000AB, wstrb 4'b1000 → mem_wen=1, mem_wstrb=1000, mem_addr=0x80000103. lsu_resp_valid pulses once and lsu_rdata=0.
- IFU and LSU valid in the same IDLE cycle, fixed priority → LSU is served first, then IFU is accepted the cycle after LSU RESP. With MEM_ARB_RR_EN and last grant=LSU, IFU is served first.
- mem_req_ready held low 5 cycles, then response delayed 3 cycles → mem fields stable throughout REQ, exactly one resp_valid pulse, and no second accept before RESP.
- Spurious mem_resp_valid in IDLE → no resp_valid on either requester and state remains IDLE.
- rst asserted during WAIT → all outputs 0 asynchronously and state=IDLE. After release, a new IFU request completes normally.
